// File: rtl/sudoku_pkg.sv
// sudoku_pkg: board geometry, visibility codes and loader states shared by selector, loader and board.
package sudoku_pkg;
  localparam int CELLS  = 81;
  localparam int CELL_W = 4;
  localparam int VIS_W  = 2;
  localparam logic [VIS_W-1:0] VIS_HIDDEN = 2'b00;
  localparam logic [VIS_W-1:0] VIS_GIVEN  = 2'b01;
  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_LOAD, ST_DONE} load_state_t;
endpackage

// File: rtl/map_cell_check.sv
// map_cell_check: classifies one cell and derives its locked flag and displayed value.
module map_cell_check
  import sudoku_pkg::*;
(
  input  logic [CELL_W-1:0] solution,
  input  logic [VIS_W-1:0]  visibility,
  output logic              valid,
  output logic              locked,
  output logic [CELL_W-1:0] display_value
);
  assign locked        = visibility == VIS_GIVEN;
  assign valid         = solution >= 4'd1 && solution <= 4'd9 && (locked || visibility == VIS_HIDDEN);
  assign display_value = locked ? solution : '0;
endmodule

// File: rtl/map_loader.sv
// map_loader: snapshots the selected map, streams it cell by cell into the board write port,
// and reports clue count, validity and a one-cycle completion pulse.
module map_loader
  import sudoku_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CELLS*CELL_W-1:0] selected_map,
  input  logic [CELLS*VIS_W-1:0]  selected_visibility,
  output logic                    busy,
  output logic                    wr_en,
  output logic [6:0]              wr_addr,
  output logic [CELL_W-1:0]       wr_value,
  output logic [CELL_W-1:0]       wr_solution,
  output logic                    wr_locked,
  output logic                    map_loaded,
  output logic [6:0]              clue_count,
  output logic                    map_error
);
  load_state_t state, state_nx;
  logic [6:0] idx;
  logic [CELLS*CELL_W-1:0] snap_map;
  logic [CELLS*VIS_W-1:0] snap_vis;
  logic [CELL_W-1:0] cur_sol, cur_disp;
  logic [VIS_W-1:0] cur_vis;
  logic cur_valid, cur_locked, load, last;
  assign cur_sol = snap_map[CELL_W*idx +: CELL_W];
  assign cur_vis = snap_vis[VIS_W*idx +: VIS_W];
  map_cell_check u_check (
    .solution      (cur_sol),
    .visibility    (cur_vis),
    .valid         (cur_valid),
    .locked        (cur_locked),
    .display_value (cur_disp)
  );
  assign load = state == ST_LOAD;
  assign last = idx == 7'(CELLS - 1);
  always_comb
    state_nx = state == ST_IDLE    ? (start ? ST_CAPTURE : ST_IDLE) :
               state == ST_CAPTURE ? ST_LOAD :
               state == ST_LOAD    ? (last ? ST_DONE : ST_LOAD) : ST_IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      snap_map   <= '0;
      snap_vis   <= '0;
      clue_count <= '0;
      map_error  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_CAPTURE) begin
        snap_map   <= selected_map;
        snap_vis   <= selected_visibility;
        idx        <= '0;
        clue_count <= '0;
        map_error  <= 1'b0;
      end else if (load) begin
        idx        <= last ? idx : idx + 7'd1;
        clue_count <= clue_count + 7'(cur_locked);
        map_error  <= map_error | ~cur_valid;
      end
    end
  // Write port is forced to zero outside LOAD so the stale snapshot never leaks out.
  assign busy        = state != ST_IDLE;
  assign wr_en       = load;
  assign wr_addr     = load ? idx : '0;
  assign wr_value    = load ? cur_disp : '0;
  assign wr_solution = load ? cur_sol : '0;
  assign wr_locked   = load & cur_locked;
  assign map_loaded  = state == ST_DONE;
endmodule

// File: tb/tb_map_loader.sv
// tb_map_loader: directed scenarios with randomized maps checked against a per-cell reference model.
module tb_map_loader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [323:0] selected_map = '0;
  logic [161:0] selected_visibility = '0;
  logic busy, wr_en, wr_locked, map_loaded, map_error;
  logic [6:0] wr_addr, clue_count;
  logic [3:0] wr_value, wr_solution;
  logic [26:0] all_out;
  int errors = 0, checks = 0;
  map_loader dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .selected_map        (selected_map),
    .selected_visibility (selected_visibility),
    .busy                (busy),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_value            (wr_value),
    .wr_solution         (wr_solution),
    .wr_locked           (wr_locked),
    .map_loaded          (map_loaded),
    .clue_count          (clue_count),
    .map_error           (map_error)
  );
  always #5 clk = ~clk;
  assign all_out = {busy, wr_en, wr_addr, wr_value, wr_solution, wr_locked, map_loaded, clue_count, map_error};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [323:0] rand_map();
    logic [323:0] m;
    for (int i = 0; i < 81; i++) m[4*i +: 4] = 4'($urandom_range(1, 9));
    return m;
  endfunction
  function automatic logic [161:0] rand_vis(input int n_given);
    logic [161:0] v = '0;
    int cnt = 0;
    while (cnt < n_given) begin
      int i = $urandom_range(0, 80);
      if (v[2*i +: 2] == 2'b00) begin
        v[2*i +: 2] = 2'b01;
        cnt++;
      end
    end
    return v;
  endfunction
  task automatic run_load(input logic [323:0] m, input logic [161:0] v, input bit mutate);
    int given_n = 0;
    bit bad = 0, given;
    logic [3:0] s;
    logic [1:0] vi;
    @(negedge clk);
    selected_map = m;
    selected_visibility = v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("capture", {busy, wr_en, map_loaded}, 3'b100);
    for (int k = 0; k < 81; k++) begin
      @(posedge clk);
      #1;
      s = m[4*k +: 4];
      vi = v[2*k +: 2];
      given = vi == 2'b01;
      if (given) given_n++;
      if (s < 1 || s > 9 || vi > 2'b01) bad = 1;
      chk($sformatf("write%0d", k), {wr_en, wr_addr, wr_value, wr_solution, wr_locked, map_loaded, busy},
          {1'b1, 7'(k), given ? s : 4'd0, s, given, 1'b0, 1'b1});
      if (mutate && k == 10) begin
        start = 1'b1;
        selected_map = rand_map();
        selected_visibility = rand_vis(50);
      end
      if (mutate && k == 12) start = 1'b0;
    end
    @(posedge clk);
    #1 chk("done", {map_loaded, busy, wr_en, clue_count, map_error}, {1'b1, 1'b1, 1'b0, 7'(given_n), bad});
    @(posedge clk);
    #1 chk("idle_after", {map_loaded, busy, wr_en, clue_count, map_error}, {3'b000, 7'(given_n), bad});
  endtask
  initial begin
    logic [323:0] m;
    logic [161:0] v;
    bit found;
    int loaded_n, wr_n;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset_with_start", all_out, 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 chk($sformatf("idle%0d", i), all_out, 0);
    end
    m = rand_map();
    v = rand_vis(20);
    m[3:0] = 4'd5;
    v[1:0] = 2'b01;
    m[323:320] = 4'd9;
    v[161:160] = 2'b00;
    run_load(m, v, 0);
    m = rand_map();
    v = rand_vis(30);
    run_load(m, v, 0);
    v[81:80] = 2'b10;
    run_load(m, v, 0);
    m = rand_map();
    v = rand_vis(25);
    m[31:28] = 4'd0;
    run_load(m, v, 0);
    run_load(rand_map(), rand_vis(35), 0);
    run_load(rand_map(), rand_vis(40), 1);
    @(negedge clk);
    selected_map = rand_map();
    selected_visibility = rand_vis(28);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(posedge clk);
      #1 found = wr_en && wr_addr == 7'd40;
    end
    chk("reach_addr40", found, 1);
    reset = 1'b1;
    #1 chk("abort_outputs", all_out, 0);
    @(negedge clk);
    reset = 1'b0;
    loaded_n = 0;
    wr_n = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      loaded_n += int'(map_loaded);
      wr_n += int'(wr_en);
    end
    chk("abort_no_pulse", loaded_n, 0);
    chk("abort_no_writes", wr_n, 0);
    run_load(rand_map(), rand_vis(33), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
